// File: rtl/pwm_pkg.sv
// Shared constants for the PWM counter generator and its compare channels.
package pwm_pkg;

    localparam int   PWM_WIDTH = 10;

    localparam logic MODE_UP   = 1'b0;
    localparam logic MODE_UPDN = 1'b1;

    localparam logic DIR_UP    = 1'b0;
    localparam logic DIR_DN    = 1'b1;

    // Reset values for the shadowed control; the reset period is all-ones at any width.
    localparam logic RST_MODE  = MODE_UP;
    localparam logic RST_DIR   = DIR_UP;

    // Registered one-cycle event outputs.
    typedef struct packed {
        logic tc;
        logic load_ack;
    } pwm_evt_t;

endpackage

// File: rtl/pwm_compare_ch.sv
// One PWM channel: pending/active duty shadow plus the registered compare output.
module pwm_compare_ch
    import pwm_pkg::*;
#(
    parameter int WIDTH = PWM_WIDTH
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             enable,
    input  logic             load,
    input  logic             apply,
    input  logic [WIDTH-1:0] duty_in,
    input  logic [WIDTH-1:0] count,
    output logic             pwm
);

    logic [WIDTH-1:0] pend_duty;
    logic [WIDTH-1:0] act_duty;

    // Capture the strobed duty; a later Load simply overwrites it.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)    pend_duty <= '0;
        else if (load) pend_duty <= duty_in;
    end

    // Swap in the new duty at the update point (a same-cycle Load wins) and compare.
    // The compare uses the duty active during this Count, so the swap never glitches.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            act_duty <= '0;
            pwm      <= 1'b0;
        end else begin
            if (apply)  act_duty <= load ? duty_in : pend_duty;
            if (enable) pwm      <= (count < act_duty);
        end
    end

endmodule

// File: rtl/pwm_counter_gen.sv
// Shared switching-frequency counter (sawtooth or triangle) with double-buffered
// period/mode and one compare channel per PWM output.
module pwm_counter_gen
    import pwm_pkg::*;
#(
    parameter int WIDTH = PWM_WIDTH,
    parameter int N_CH  = 2
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Enable,
    input  logic                  Load,
    input  logic                  Mode,
    input  logic [WIDTH-1:0]      Period,
    input  logic [N_CH*WIDTH-1:0] Duty,
    output logic [WIDTH-1:0]      Count,
    output logic [N_CH-1:0]       Pwm_out,
    output logic                  Tc,
    output logic                  Load_ack
);

    logic             dir;
    logic             first_vly;
    logic             act_mode;
    logic [WIDTH-1:0] act_p;
    logic             pend_mode;
    logic [WIDTH-1:0] pend_p;
    logic             pend_vld;
    pwm_evt_t         evt;

    logic             upd;
    logic             apply;
    logic [WIDTH-1:0] cnt_nxt;
    logic             dir_nxt;

    // Update point: period end for sawtooth, valley on the way down for triangle.
    // The >= guards keep the counter from ever running past P.
    always_comb begin
        upd = 1'b0;
        if (act_p == '0)             upd = 1'b1;
        else if (act_mode == MODE_UP) upd = (Count >= act_p);
        else                          upd = (Count == '0) && ((dir == DIR_DN) || first_vly);
    end

    assign apply = Enable && upd && (pend_vld || Load);

    // Next counter value and direction.
    always_comb begin
        cnt_nxt = Count;
        dir_nxt = dir;
        if (apply || act_p == '0) begin
            cnt_nxt = '0;
            dir_nxt = DIR_UP;
        end else if (act_mode == MODE_UP) begin
            cnt_nxt = (Count >= act_p) ? '0 : Count + 1'b1;
            dir_nxt = DIR_UP;
        end else if (dir == DIR_UP) begin
            if (Count >= act_p) begin
                cnt_nxt = act_p - 1'b1;
                dir_nxt = DIR_DN;
            end else begin
                cnt_nxt = Count + 1'b1;
            end
        end else if (Count == '0) begin
            cnt_nxt = {{(WIDTH-1){1'b0}}, 1'b1};
            dir_nxt = DIR_UP;
        end else begin
            cnt_nxt = Count - 1'b1;
        end
    end

    // Counter, direction, active period/mode and the event pulses.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            Count     <= '0;
            dir       <= RST_DIR;
            first_vly <= 1'b1;
            act_mode  <= RST_MODE;
            act_p     <= '1;
            evt       <= '0;
        end else begin
            evt.tc       <= Enable && upd;
            evt.load_ack <= apply;
            if (Enable) begin
                Count     <= cnt_nxt;
                dir       <= dir_nxt;
                first_vly <= 1'b0;
            end
            if (apply) begin
                act_mode <= Load ? Mode : pend_mode;
                act_p    <= Load ? Period : pend_p;
            end
        end
    end

    // Pending shadow: applying always consumes the flag, including a same-cycle Load.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            pend_mode <= RST_MODE;
            pend_p    <= '1;
            pend_vld  <= 1'b0;
        end else begin
            if (Load) begin
                pend_mode <= Mode;
                pend_p    <= Period;
            end
            if (apply)     pend_vld <= 1'b0;
            else if (Load) pend_vld <= 1'b1;
        end
    end

    assign Tc       = evt.tc;
    assign Load_ack = evt.load_ack;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        pwm_compare_ch #(.WIDTH(WIDTH)) u_ch (
            .Clk     (Clk),
            .Reset   (Reset),
            .enable  (Enable),
            .load    (Load),
            .apply   (apply),
            .duty_in (Duty[i*WIDTH +: WIDTH]),
            .count   (Count),
            .pwm     (Pwm_out[i])
        );
    end

endmodule

// File: tb/tb_pwm_counter_gen.sv
// Self-checking bench for pwm_counter_gen (WIDTH = 10, N_CH = 2).
module tb_pwm_counter_gen;

    localparam int W = 10;
    localparam int N = 2;

    logic           Clk = 1'b0;
    logic           Reset, Enable, Load, Mode;
    logic [W-1:0]   Period;
    logic [N*W-1:0] Duty;
    logic [W-1:0]   Count;
    logic [N-1:0]   Pwm_out;
    logic           Tc, Load_ack;

    pwm_counter_gen #(.WIDTH(W), .N_CH(N)) dut (
        .Clk(Clk), .Reset(Reset), .Enable(Enable), .Load(Load), .Mode(Mode),
        .Period(Period), .Duty(Duty), .Count(Count), .Pwm_out(Pwm_out),
        .Tc(Tc), .Load_ack(Load_ack)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] cnt;
        logic [N-1:0] pwm;
        logic         pwm_chk;
        logic         tc;
        logic         ack;
    } exp_t;

    typedef struct {
        logic         en;
        logic [W-1:0] cnt;
    } vec_t;

    exp_t sbq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic pop_cmp(input string tag);
        exp_t e;
        if (sbq.size() == 0) begin
            chk({tag, "_sb_empty"}, 1, 0);
        end else begin
            e = sbq.pop_front();
            chk({tag, "_cnt"}, 32'(Count), 32'(e.cnt));
            if (e.pwm_chk) chk({tag, "_pwm"}, 32'(Pwm_out), 32'(e.pwm));
            chk({tag, "_tc"}, 32'(Tc), 32'(e.tc));
            chk({tag, "_ack"}, 32'(Load_ack), 32'(e.ack));
        end
    endtask

    task automatic step_exp(input logic [W-1:0] c, input logic [N-1:0] pw, input logic t,
                            input logic a, input string tag);
        exp_t e;
        e.cnt = c; e.pwm = pw; e.pwm_chk = 1'b1; e.tc = t; e.ack = a;
        sbq.push_back(e);
        tick();
        pop_cmp(tag);
    endtask

    // Ideal counter value k cycles after a new setting takes effect.
    function automatic int seqv(int k, logic md, int p);
        int m;
        if (p == 0) return 0;
        if (!md) return k % (p + 1);
        m = k % (2 * p);
        return (m <= p) ? m : 2 * p - m;
    endfunction

    function automatic exp_t gen(int k, logic md, int p, int d0, int d1);
        exp_t e;
        int   prev;
        e.cnt = W'(seqv(k, md, p));
        e.ack = (k == 0);
        if (k == 0) begin
            e.tc = 1'b1; e.pwm = '0; e.pwm_chk = 1'b0;
        end else begin
            prev      = seqv(k - 1, md, p);
            e.pwm     = {prev < d1, prev < d0};
            e.pwm_chk = 1'b1;
            if (p == 0)   e.tc = 1'b1;
            else if (!md) e.tc = (prev == p);
            else          e.tc = (((k - 1) % (2 * p)) == 0) && (k > 1);
        end
        return e;
    endfunction

    // Entered on the cycle Load_ack is seen; checks n cycles of the new period.
    task automatic run_check(input logic md, input int p, input int d0, input int d1,
                             input int n, input string tag);
        sbq.push_back(gen(0, md, p, d0, d1));
        pop_cmp(tag);
        for (int k = 1; k < n; k++) begin
            sbq.push_back(gen(k, md, p, d0, d1));
            tick();
            pop_cmp(tag);
        end
    endtask

    task automatic do_load(input logic md, input int p, input int d0, input int d1);
        Mode = md; Period = W'(p); Duty = {W'(d1), W'(d0)};
        Load = 1'b1;
        tick();
        Load = 1'b0;
    endtask

    task automatic wait_ack(input int maxc, input string tag, output int w);
        w = 0;
        while (!Load_ack && w < maxc) begin
            tick();
            w++;
        end
        chk({tag, "_ack_seen"}, 32'(Load_ack), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[7];
        int   w, h0, h1, nt;

        vt[0] = '{1'b1, 10'd1}; vt[1] = '{1'b1, 10'd2}; vt[2] = '{1'b1, 10'd3};
        vt[3] = '{1'b0, 10'd3}; vt[4] = '{1'b0, 10'd3}; vt[5] = '{1'b1, 10'd4};
        vt[6] = '{1'b1, 10'd5};

        Reset = 1'b0; Enable = 1'b0; Load = 1'b0; Mode = 1'b0; Period = '0; Duty = '0;
        #12;
        chk("rst_cnt", 32'(Count), 0);
        chk("rst_pwm", 32'(Pwm_out), 0);
        chk("rst_tc", 32'(Tc), 0);
        chk("rst_ack", 32'(Load_ack), 0);
        @(negedge Clk);
        Reset = 1'b1;

        // Default period is all-ones, so the counter just climbs after release.
        for (int i = 0; i < 7; i++) begin
            Enable = vt[i].en;
            step_exp(vt[i].cnt, 2'b00, 1'b0, 1'b0, "vec");
        end

        // Asynchronous reset mid-count, away from any clock edge.
        #2 Reset = 1'b0;
        #1;
        chk("arst_cnt", 32'(Count), 0);
        chk("arst_pwm", 32'(Pwm_out), 0);
        chk("arst_tc", 32'(Tc), 0);
        @(negedge Clk);
        Reset = 1'b1;
        step_exp(10'd1, 2'b00, 1'b0, 1'b0, "rel");

        // Sawtooth P = 9, duty {3,7}.
        do_load(1'b0, 9, 3, 7);
        wait_ack(1100, "saw", w);
        run_check(1'b0, 9, 3, 7, 30, "saw");
        h0 = 0; h1 = 0; nt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            h0 += int'(Pwm_out[0]);
            h1 += int'(Pwm_out[1]);
            nt += int'(Tc);
        end
        chk("saw_ch0_high", h0, 3);
        chk("saw_ch1_high", h1, 7);
        chk("saw_tc_count", nt, 1);

        // Triangle P = 4, duty {2,0}.
        do_load(1'b1, 4, 2, 0);
        wait_ack(30, "tri", w);
        run_check(1'b1, 4, 2, 0, 26, "tri");

        // Two loads before the valley: only the second lands, at the valley.
        do_load(1'b0, 5, 3, 7);
        tick();
        do_load(1'b0, 3, 1, 2);
        wait_ack(20, "lastwin", w);
        chk("lastwin_ack_cycle", w, 5);
        run_check(1'b0, 3, 1, 2, 12, "lastwin");

        // Duty above the period: output stuck high.
        do_load(1'b0, 9, 12, 12);
        wait_ack(20, "full", w);
        run_check(1'b0, 9, 12, 12, 22, "full");

        // P = 0: counter pinned at 0, Tc every cycle.
        do_load(1'b0, 0, 0, 1);
        wait_ack(20, "p0", w);
        run_check(1'b0, 0, 0, 1, 6, "p0");

        // Load on an update point is applied at that same edge.
        do_load(1'b1, 0, 1, 0);
        wait_ack(5, "same", w);
        chk("same_ack_cycle", w, 0);
        run_check(1'b1, 0, 1, 0, 4, "same");

        // Load accepted while disabled; nothing moves until Enable returns.
        Enable = 1'b0;
        do_load(1'b0, 9, 3, 7);
        pop_cmp_dis: begin
            exp_t e;
            e.cnt = '0; e.pwm = 2'b01; e.pwm_chk = 1'b1; e.tc = 1'b0; e.ack = 1'b0;
            sbq.push_back(e);
            pop_cmp("dis_load");
        end
        for (int i = 0; i < 3; i++) step_exp(10'd0, 2'b01, 1'b0, 1'b0, "dis");
        Enable = 1'b1;
        tick();
        wait_ack(5, "resume", w);
        chk("resume_ack_cycle", w, 0);
        run_check(1'b0, 9, 3, 7, 7, "resume");

        // Hold at Count = 6 for 5 cycles, then resume at 7.
        Enable = 1'b0;
        for (int i = 0; i < 5; i++) step_exp(10'd6, 2'b10, 1'b0, 1'b0, "hold");
        Enable = 1'b1;
        step_exp(10'd7, 2'b10, 1'b0, 1'b0, "unhold");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
